// File: rtl/timer_arbiter.sv
// Shared down-counting delay timer, granted round-robin to NUM_REQ requesters.
// The winner holds the timer for delay+1 cycles and then gets a one-cycle done pulse.
module timer_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                           clk_in,
  input  logic                           reset_n_in,
  input  logic [NUM_REQ-1:0]             req_in,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] delay_in,
  output logic [NUM_REQ-1:0]             grant_out,
  output logic [NUM_REQ-1:0]             done_out,
  output logic                           busy_out
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW:0] NR = NUM_REQ[IW:0];
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    RELEASE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [COUNT_WIDTH-1:0] cnt_d;
  logic [IW-1:0]          ptr_q;
  logic [IW-1:0]          ptr_d;
  logic [IW-1:0]          own_q;
  logic [IW-1:0]          own_d;
  logic [IW-1:0]          own_nxt;
  logic [IW-1:0]          win;
  logic [NUM_REQ-1:0]     grant_d;
  logic [NUM_REQ-1:0]     done_d;
  logic [COUNT_WIDTH-1:0] dly [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_dly
    assign dly[g] = delay_in[g*COUNT_WIDTH +: COUNT_WIDTH];
  end

  // Walk from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    logic [IW:0] c;
    c   = '0;
    win = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      c = {1'b0, ptr_q} + (IW+1)'(i);
      if (c >= NR) c = c - NR;
      if (req_in[c[IW-1:0]]) win = c[IW-1:0];
    end
  end

  assign own_nxt = (own_q == LAST) ? '0 : own_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    grant_d = grant_out;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (|req_in) begin
          state_d      = COUNT;
          own_d        = win;
          cnt_d        = dly[win];
          grant_d[win] = 1'b1;
        end
      end
      COUNT: begin
        if (!req_in[own_q]) begin
          state_d = RELEASE;
          grant_d = '0;
          ptr_d   = own_nxt;
        end else if (cnt_q == '0) begin
          state_d        = RELEASE;
          grant_d        = '0;
          done_d[own_q]  = 1'b1;
          ptr_d          = own_nxt;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      own_q     <= '0;
      grant_out <= '0;
      done_out  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      grant_out <= grant_d;
      done_out  <= done_d;
    end
  end

  assign busy_out = (state_q != IDLE);

  a_grant_oh: assert property (@(posedge clk_in) disable iff (!reset_n_in)
    $onehot0(grant_out));
  a_done_oh: assert property (@(posedge clk_in) disable iff (!reset_n_in)
    $onehot0(done_out));
  a_no_overlap: assert property (@(posedge clk_in) disable iff (!reset_n_in)
    (grant_out & done_out) == '0);

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: vector table plus
// hand-written multi-cycle sequences.
module tb_timer_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] dly;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  timer_arbiter #(
    .NUM_REQ    (4),
    .COUNT_WIDTH(16)
  ) dut (
    .clk_in    (clk),
    .reset_n_in(rst_n),
    .req_in    (req),
    .delay_in  (dly),
    .grant_out (grant),
    .done_out  (done),
    .busy_out  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [63:0] dly;
    logic [3:0]  eg;
    logic [3:0]  ed;
    logic        eb;
  } vec_t;

  vec_t tab [64];
  int   n_tab = 0;

  task automatic add(input logic r, input logic [3:0] rq,
                     input logic [63:0] d, input logic [3:0] eg,
                     input logic [3:0] ed, input logic eb);
    tab[n_tab] = '{rst: r, req: rq, dly: d, eg: eg, ed: ed, eb: eb};
    n_tab++;
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Entered and left at a falling edge; reset state checked while held.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] d5;
    logic [63:0] d3;
    logic [3:0]  oh;
    int          n;
    bit          seen_end;

    rst_n = 1'b0;
    req   = '0;
    dly   = '0;

    d5 = 64'd5;
    d3 = {16'd3, 16'd3, 16'd3, 16'd3};

    // single requester, delay 5: 6 grant cycles, done, then idle
    add(1'b1, 4'b0001, d5, 4'b0001, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++)
      add(1'b0, 4'b0001, d5, 4'b0001, 4'b0000, 1'b1);
    add(1'b0, 4'b0001, d5, 4'b0000, 4'b0001, 1'b1);
    add(1'b0, 4'b0000, d5, 4'b0000, 4'b0000, 1'b0);
    add(1'b0, 4'b0000, d5, 4'b0000, 4'b0000, 1'b0);

    // all four held, delay 3: strict rotation with 2-cycle gaps
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << (g % 4);
      for (int c = 0; c < 4; c++)
        add((g == 0 && c == 0), 4'b1111, d3, oh, 4'b0000, 1'b1);
      if (g < 4) begin
        add(1'b0, 4'b1111, d3, 4'b0000, oh, 1'b1);
        add(1'b0, 4'b1111, d3, 4'b0000, 4'b0000, 1'b0);
      end
    end

    @(negedge clk);
    for (int i = 0; i < n_tab; i++) begin
      if (tab[i].rst) do_reset();
      req = tab[i].req;
      dly = tab[i].dly;
      @(negedge clk);
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tab[i].eg));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tab[i].ed));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tab[i].eb));
    end

    // delay 0: one-cycle grant, then done with grant already low
    do_reset();
    req = 4'b0001;
    dly = '0;
    @(negedge clk);
    chk("d0_grant", 32'(grant), 32'h1);
    @(negedge clk);
    chk("d0_grant_off", 32'(grant), 32'h0);
    chk("d0_done", 32'(done), 32'h1);
    req = '0;
    @(negedge clk);
    chk("d0_idle_busy", 32'(busy), 32'h0);
    chk("d0_idle_done", 32'(done), 32'h0);

    // abort req2 at count 50; ptr moves to 3 so req3 beats req0
    do_reset();
    req = 4'b0100;
    dly = '0;
    dly[32 +: 16] = 16'd100;
    dly[48 +: 16] = 16'd2;
    @(negedge clk);
    chk("ab_grant", 32'(grant), 32'h4);
    repeat (50) @(negedge clk);
    chk("ab_grant_mid", 32'(grant), 32'h4);
    req = 4'b1001;
    @(negedge clk);
    chk("ab_grant_off", 32'(grant), 32'h0);
    chk("ab_no_done", 32'(done), 32'h0);
    chk("ab_rel_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("ab_idle_busy", 32'(busy), 32'h0);
    chk("ab_idle_done", 32'(done), 32'h0);
    @(negedge clk);
    chk("ab_next_grant", 32'(grant), 32'h8);

    // async reset mid-count clears outputs and the pointer
    do_reset();
    req = 4'b0010;
    dly = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rs_done1", 32'(done), 32'h2);
    req = '0;
    @(negedge clk);
    req = 4'b0100;
    dly[32 +: 16] = 16'd10;
    @(negedge clk);
    chk("rs_grant2", 32'(grant), 32'h4);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_async_grant", 32'(grant), 32'h0);
    chk("rs_async_done", 32'(done), 32'h0);
    chk("rs_async_busy", 32'(busy), 32'h0);
    req = 4'b0110;
    @(negedge clk);
    chk("rs_held_grant", 32'(grant), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rs_ptr0_grant", 32'(grant), 32'h2);

    // delay change after grant is ignored
    do_reset();
    req = 4'b0001;
    dly = 64'd4;
    @(negedge clk);
    chk("dc_grant", 32'(grant), 32'h1);
    dly = 64'd20;
    n = 1;
    seen_end = 1'b0;
    for (int k = 0; k < 40 && !seen_end; k++) begin
      @(negedge clk);
      if (grant == 4'b0001) n++;
      else seen_end = 1'b1;
    end
    chk("dc_end_seen", 32'(seen_end), 32'h1);
    chk("dc_len", 32'(n), 32'd5);
    chk("dc_done", 32'(done), 32'h1);
    req = '0;
    @(negedge clk);
    chk("dc_idle_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
